apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream APB2 requester: converts a simple valid/ready command stream into APB2 SETUP/ACCESS transfers on the team's APB interface signal set.
- Returns read data and completion as a one-cycle response pulse.
- Sits between the test/sequence layer or a CPU-side port and any APB2 slave (DUT modport side).

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA/req_wdata/rsp_rdata.
- ADDR_WIDTH, 16, width of PADDR/req_addr.
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  synchronous active-high reset.
- req_valid  input  1  command present.
- req_ready  output  1  bridge can accept a command this cycle.
- req_addr  input  ADDR_WIDTH  command address.
- req_write  input  1  1 = write, 0 = read.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_timeout  output  1  completion was a timeout abort; qualified by rsp_valid.
- PADDR  output  ADDR_WIDTH  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_WIDTH  APB write data.
- PSELx  output  1  APB slave select.
- PENABLE  output  1  APB access phase.
- PREADY  input  1  slave ready.
- PRDATA  input  DATA_WIDTH  slave read data.

Behaviour:
- Interface decision: one clock PCLK; reset PRESET is synchronous and active-high.
- Reset: state=IDLE. PADDR, PWRITE, PWDATA, PSELx, PENABLE, rsp_valid, rsp_rdata and rsp_timeout = 0. All take effect on the first PCLK edge with PRESET=1.
- FSM IDLE/SETUP/ACCESS. All APB outputs are registered.
- IDLE:
  - PSELx=0, PENABLE=0; req_ready=1.
  - req_valid&&req_ready: latch addr/write/wdata into PADDR/PWRITE/PWDATA, go to SETUP.
- SETUP: PSELx=1, PENABLE=0, req_ready=0; unconditionally go to ACCESS.
- ACCESS with PREADY=0: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
- ACCESS with PREADY=1 (transfer completes this edge):
  - Next cycle: rsp_valid=1, rsp_timeout=0, rsp_rdata = PRDATA if PWRITE=0, else 0.
  - req_ready=1 combinationally in this cycle. If req_valid=1, latch the new command and go straight to SETUP (back-to-back, PENABLE drops, PSELx stays 1). Otherwise go to IDLE.
- req_ready is 0 in SETUP and in ACCESS while PREADY=0. Commands presented then are not consumed and must be held by the requester.
- Latency:
  - Accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2.
  - With zero wait states, rsp_valid is high in cycle N+3.
  - Each PREADY-low cycle adds 1.
  - Back-to-back throughput is 2 cycles/transfer.
- rsp_valid is exactly one cycle per accepted command. No responses are dropped or duplicated.
- Reset mid-transfer (any state): behaves as reset; no rsp_valid for the aborted command; PSELx/PENABLE are 0 after that edge.
- PREADY and PRDATA are ignored outside ACCESS.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, go to IDLE: PSELx=0 and PENABLE=0 next cycle.
  - Same next cycle: rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in the same cycle the limit is reached counts as a normal completion.
- Undefined: the bridge waits indefinitely; rsp_timeout is constant 0; no counter logic.

Decomposition:
- Package apb_master_pkg:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS}.
  - Default DATA_WIDTH/ADDR_WIDTH localparams.
  - Response struct {rdata, timeout}.
- Sub-module apb_wait_timer: counter plus limit compare. Instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write addr 0x0010, data 0xDEADBEEF, PREADY tied 1 -> PSELx=1,PENABLE=0 for 1 cycle, then PENABLE=1 for 1 cycle with stable PADDR/PWDATA; rsp_valid pulse, rsp_rdata=0.
- Read addr 0x0020, PREADY low 2 ACCESS cycles, PRDATA=0x12345678 -> ACCESS lasts 3 cycles; rsp_rdata=0x12345678 on the single rsp_valid pulse.
- Three back-to-back commands with req_valid held high, PREADY=1 -> 6 cycles total, PSELx never drops, 3 rsp_valid pulses in order.
- req_valid asserted during SETUP/ACCESS -> req_ready=0, command not consumed until completion.
- PRESET asserted in ACCESS with PREADY=0 -> next cycle PSELx=0, PENABLE=0, state IDLE, no rsp_valid.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles; rsp_valid=1, rsp_timeout=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB2 master bridge.
package apb_master_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Response payload registered alongside the one-cycle completion pulse.
  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low and flags the cycle whose increment reaches LIMIT.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged in the same cycle as the increment that would reach LIMIT.
  assign expired_o = inc_i && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB2 SETUP/ACCESS requester with a one-cycle response pulse.
// Optional ACCESS wait-state abort enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rspValid_q, rspValid_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  readyComb;
  logic                  accept;
  logic                  waitExpired;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (PCLK),
    .reset_i  (PRESET),
    .clear_i  (state_q == SETUP),
    .inc_i    ((state_q == ACCESS) && !PREADY),
    .expired_o(waitExpired)
  );
`else
  logic unusedTimeoutCfg;
  assign waitExpired      = 1'b0;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES == 0);
`endif

  // A completing ACCESS frees the bridge in the same cycle for back-to-back commands.
  assign readyComb = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
  assign accept    = req_valid && readyComb;

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    rspValid_d = 1'b0;
    rsp_d      = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rspValid_d = 1'b1;
          rsp_d.rdata = pwrite_q ? '0 : APB_DATA_WIDTH'(PRDATA);
          state_d = accept ? SETUP : IDLE;
        end else if (waitExpired) begin
          rspValid_d    = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      paddr_d  = req_addr;
      pwrite_d = req_write;
      pwdata_d = req_wdata;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      rspValid_q <= 1'b0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      rspValid_q <= rspValid_d;
      rsp_q      <= rsp_d;
    end
  end

  assign req_ready   = readyComb;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; timeout scenarios run when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSELx;
  logic        PENABLE;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkApb(input string tag, input logic psel, input logic penable, input logic rspv);
    checkOutput({tag, "_psel"}, 32'(PSELx), 32'(psel));
    checkOutput({tag, "_penable"}, 32'(PENABLE), 32'(penable));
    checkOutput({tag, "_rspvalid"}, 32'(rsp_valid), 32'(rspv));
  endtask

  // Moves to just after the next rising edge so registered outputs are settled.
  task automatic waitCycle();
    @(posedge PCLK);
    #2;
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [15:0] addr,
                               input logic [31:0] wdata);
    req_valid = valid;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
  endtask

  logic [15:0] b2bAddr  [3] = '{16'h0100, 16'h0104, 16'h0108};
  logic        b2bWrite [3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] b2bWdata [3] = '{32'h1111_1111, 32'h0, 32'h0};
  logic [31:0] b2bPrdata[3] = '{32'hFFFF_FFFF, 32'h0BAD_F00D, 32'hCAFE_0002};
  logic [31:0] b2bExpRd [3] = '{32'h0, 32'h0BAD_F00D, 32'hCAFE_0002};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    waitCycle();
    waitCycle();
    checkApb("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset_paddr", 32'(PADDR), 32'h0);
    checkOutput("reset_pwrite", 32'(PWRITE), 32'h0);
    checkOutput("reset_pwdata", PWDATA, 32'h0);
    checkOutput("reset_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_timeout", 32'(rsp_timeout), 32'h0);
    PRESET = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'h1);

    // Single write, zero wait states
    PREADY = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    checkOutput("wr_ready_idle", 32'(req_ready), 32'h1);
    waitCycle();
    checkApb("wr_setup", 1'b1, 1'b0, 1'b0);
    checkOutput("wr_setup_paddr", 32'(PADDR), 32'h0010);
    checkOutput("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
    checkOutput("wr_setup_pwrite", 32'(PWRITE), 32'h1);
    checkOutput("wr_setup_ready", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    waitCycle();
    checkApb("wr_access", 1'b1, 1'b1, 1'b0);
    checkOutput("wr_access_paddr", 32'(PADDR), 32'h0010);
    checkOutput("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
    checkOutput("wr_access_ready", 32'(req_ready), 32'h1);
    waitCycle();
    checkApb("wr_rsp", 1'b0, 1'b0, 1'b1);
    checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("wr_rsp_timeout", 32'(rsp_timeout), 32'h0);
    waitCycle();
    checkApb("wr_after", 1'b0, 1'b0, 1'b0);

    // Read with two wait states
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0, 16'h0020, 32'h0);
    waitCycle();
    checkApb("rd_setup", 1'b1, 1'b0, 1'b0);
    checkOutput("rd_setup_paddr", 32'(PADDR), 32'h0020);
    checkOutput("rd_setup_pwrite", 32'(PWRITE), 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    waitCycle();
    checkApb("rd_acc1", 1'b1, 1'b1, 1'b0);
    checkOutput("rd_acc1_ready", 32'(req_ready), 32'h0);
    waitCycle();
    checkApb("rd_acc2", 1'b1, 1'b1, 1'b0);
    waitCycle();
    PREADY = 1'b1;
    #1;
    checkApb("rd_acc3", 1'b1, 1'b1, 1'b0);
    checkOutput("rd_acc3_ready", 32'(req_ready), 32'h1);
    waitCycle();
    checkApb("rd_rsp", 1'b0, 1'b0, 1'b1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    checkOutput("rd_rsp_timeout", 32'(rsp_timeout), 32'h0);
    waitCycle();
    checkApb("rd_after", 1'b0, 1'b0, 1'b0);

    // Three back-to-back commands, req_valid held high
    applyStimulus(1'b1, b2bWrite[0], b2bAddr[0], b2bWdata[0]);
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkApb($sformatf("b2b%0d_setup", i), 1'b1, 1'b0, (i > 0));
      checkOutput($sformatf("b2b%0d_setup_paddr", i), 32'(PADDR), 32'(b2bAddr[i]));
      checkOutput($sformatf("b2b%0d_setup_ready", i), 32'(req_ready), 32'h0);
      if (i > 0) begin
        checkOutput($sformatf("b2b%0d_rsp_rdata", i - 1), rsp_rdata, b2bExpRd[i-1]);
      end
      if (i < 2) begin
        applyStimulus(1'b1, b2bWrite[i+1], b2bAddr[i+1], b2bWdata[i+1]);
      end else begin
        applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
      end
      PRDATA = b2bPrdata[i];
      waitCycle();
      checkApb($sformatf("b2b%0d_access", i), 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("b2b%0d_access_paddr", i), 32'(PADDR), 32'(b2bAddr[i]));
      checkOutput($sformatf("b2b%0d_access_pwrite", i), 32'(PWRITE), 32'(b2bWrite[i]));
    end
    waitCycle();
    checkApb("b2b_end", 1'b0, 1'b0, 1'b1);
    checkOutput("b2b2_rsp_rdata", rsp_rdata, b2bExpRd[2]);
    waitCycle();
    checkApb("b2b_after", 1'b0, 1'b0, 1'b0);

    // Command held while the bridge is busy with wait states
    PREADY = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h0200, 32'h2222_2222);
    waitCycle();
    applyStimulus(1'b1, 1'b0, 16'h0204, 32'h0);
    checkOutput("hold_setup_ready", 32'(req_ready), 32'h0);
    waitCycle();
    checkOutput("hold_acc1_ready", 32'(req_ready), 32'h0);
    checkOutput("hold_acc1_paddr", 32'(PADDR), 32'h0200);
    checkOutput("hold_acc1_pwdata", PWDATA, 32'h2222_2222);
    waitCycle();
    checkOutput("hold_acc2_ready", 32'(req_ready), 32'h0);
    checkOutput("hold_acc2_paddr", 32'(PADDR), 32'h0200);
    PREADY = 1'b1;
    #1;
    checkOutput("hold_acc2_done_ready", 32'(req_ready), 32'h1);
    waitCycle();
    checkApb("hold_b_setup", 1'b1, 1'b0, 1'b1);
    checkOutput("hold_a_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("hold_b_paddr", 32'(PADDR), 32'h0204);
    checkOutput("hold_b_pwrite", 32'(PWRITE), 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    PRDATA = 32'h4444_4444;
    waitCycle();
    checkApb("hold_b_access", 1'b1, 1'b1, 1'b0);
    waitCycle();
    checkApb("hold_b_rsp", 1'b0, 1'b0, 1'b1);
    checkOutput("hold_b_rsp_rdata", rsp_rdata, 32'h4444_4444);

    // Reset while waiting in ACCESS
    PREADY = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h0300, 32'h3333_3333);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    waitCycle();
    waitCycle();
    checkApb("rst_mid_access", 1'b1, 1'b1, 1'b0);
    PRESET = 1'b1;
    waitCycle();
    checkApb("rst_mid_after", 1'b0, 1'b0, 1'b0);
    checkOutput("rst_mid_paddr", 32'(PADDR), 32'h0);
    PRESET = 1'b0;
    PREADY = 1'b1;
    #1;
    checkOutput("rst_mid_ready", 32'(req_ready), 32'h1);
    waitCycle();
    checkApb("rst_mid_norsp", 1'b0, 1'b0, 1'b0);

`ifdef APB_TIMEOUT_EN
    // Abort after four ACCESS cycles with PREADY low
    PREADY = 1'b0;
    PRDATA = 32'h5555_5555;
    applyStimulus(1'b1, 1'b0, 16'h0400, 32'h0);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      waitCycle();
      checkApb($sformatf("to_acc%0d", i), 1'b1, 1'b1, 1'b0);
    end
    waitCycle();
    checkApb("to_abort", 1'b0, 1'b0, 1'b1);
    checkOutput("to_abort_timeout", 32'(rsp_timeout), 32'h1);
    checkOutput("to_abort_rdata", rsp_rdata, 32'h0);
    waitCycle();
    checkApb("to_after", 1'b0, 1'b0, 1'b0);

    // PREADY rising on the limit cycle completes normally
    PRDATA = 32'h7777_7777;
    applyStimulus(1'b1, 1'b0, 16'h0404, 32'h0);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      waitCycle();
    end
    PREADY = 1'b1;
    #1;
    checkApb("to_limit_acc4", 1'b1, 1'b1, 1'b0);
    waitCycle();
    checkApb("to_limit_rsp", 1'b0, 1'b0, 1'b1);
    checkOutput("to_limit_timeout", 32'(rsp_timeout), 32'h0);
    checkOutput("to_limit_rdata", rsp_rdata, 32'h7777_7777);
`else
    // Without the timeout feature the bridge waits indefinitely
    PREADY = 1'b0;
    PRDATA = 32'h6666_6666;
    applyStimulus(1'b1, 1'b0, 16'h0500, 32'h0);
    waitCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      waitCycle();
    end
    checkApb("nto_wait", 1'b1, 1'b1, 1'b0);
    PREADY = 1'b1;
    waitCycle();
    checkApb("nto_rsp", 1'b0, 1'b0, 1'b1);
    checkOutput("nto_rsp_rdata", rsp_rdata, 32'h6666_6666);
    checkOutput("nto_rsp_timeout", 32'(rsp_timeout), 32'h0);
`endif

    waitCycle();
    checkApb("final_idle", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
